// File: rtl/sma_rr_scheduler_if.sv
// Bundle between N_CH sample sources, the shared SMA scheduler and the averaged-sample sink.
// Handshake: a sample moves when in_valid[i]&in_ready[i] at a rising clk edge, and a result moves when out_valid&out_ready; valid never waits on ready.
interface sma_rr_scheduler_if #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 16
) ();
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0]        in_valid;
  logic [N_CH*DATA_W-1:0] in_data;
  logic [N_CH-1:0]        in_ready;
  logic                   flush;
  logic                   out_valid;
  logic [DATA_W-1:0]      out_data;
  logic [CH_W-1:0]        out_ch;
  logic                   out_ready;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/sma_rr_scheduler.sv
// One moving-average engine time-shared round-robin across N_CH streams,
// with per-channel history and accumulator so each channel behaves like a dedicated SMA.
module sma_rr_scheduler #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 16,
  parameter int WIN    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  sma_rr_scheduler_if.slave    bus,
  output logic [1:0]           state_dbg
);
  localparam int LOG2_WIN = $clog2(WIN);
  localparam int ACC_W    = DATA_W + LOG2_WIN;
  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPUTE = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;

  localparam logic signed [ACC_W-1:0] WIN_M1 = ACC_W'(WIN - 1);

  logic [1:0]               state;
  logic [CH_W-1:0]          rr_ptr;
  logic                     flush_pend;
  logic signed [DATA_W-1:0] x_reg;
  logic [CH_W-1:0]          ch_reg;
  logic signed [DATA_W-1:0] hist [N_CH][WIN];
  logic signed [ACC_W-1:0]  acc  [N_CH];

  logic                     grant_found;
  logic [CH_W-1:0]          grant_idx;
  logic signed [DATA_W-1:0] grant_data;
  logic signed [ACC_W-1:0]  acc_n;
  logic signed [ACC_W-1:0]  acc_adj;
  logic signed [ACC_W-1:0]  quo;
  logic                     unused_quo_bits;

  assign state_dbg = state;

  // Descending scan so the channel closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    int idx_i;
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_data  = '0;
    idx_i       = 0;
    if (rst && state == IDLE && !flush_pend && !bus.flush) begin
      for (int k = N_CH - 1; k >= 0; k--) begin
        idx_i = (int'(rr_ptr) + k) % N_CH;
        if (bus.in_valid[idx_i]) begin
          grant_found = 1'b1;
          grant_idx   = CH_W'(idx_i);
          grant_data  = bus.in_data[idx_i*DATA_W +: DATA_W];
        end
      end
    end
    bus.in_ready = grant_found ? (N_CH'(1) << grant_idx) : '0;
  end

  // Bias negative sums by WIN-1 so the arithmetic shift truncates toward zero.
  always_comb begin
    acc_n   = acc[ch_reg] - ACC_W'(hist[ch_reg][WIN-1]) + ACC_W'(x_reg);
    acc_adj = acc_n[ACC_W-1] ? (acc_n + WIN_M1) : acc_n;
    quo     = acc_adj >>> LOG2_WIN;
  end

  assign unused_quo_bits = ^quo[ACC_W-2:DATA_W-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      flush_pend    <= 1'b0;
      x_reg         <= '0;
      ch_reg        <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
      for (int i = 0; i < N_CH; i++) begin
        acc[i] <= '0;
        for (int k = 0; k < WIN; k++) hist[i][k] <= '0;
      end
    end else begin
      if (bus.flush) flush_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (flush_pend || bus.flush) begin
            flush_pend <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
              acc[i] <= '0;
              for (int k = 0; k < WIN; k++) hist[i][k] <= '0;
            end
          end else if (grant_found) begin
            x_reg  <= grant_data;
            ch_reg <= grant_idx;
            state  <= COMPUTE;
          end
        end
        COMPUTE: begin
          acc[ch_reg]     <= acc_n;
          hist[ch_reg][0] <= x_reg;
          for (int k = 1; k < WIN; k++) hist[ch_reg][k] <= hist[ch_reg][k-1];
          bus.out_data  <= {quo[ACC_W-1], quo[DATA_W-2:0]};
          bus.out_ch    <= ch_reg;
          bus.out_valid <= 1'b1;
          state         <= HOLD;
        end
        HOLD: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            rr_ptr        <= (ch_reg == CH_W'(N_CH - 1)) ? '0 : ch_reg + 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sma_rr_scheduler.sv
// Directed bench for sma_rr_scheduler: drivers push hand-computed results into a queue,
// a negedge monitor pops and compares each delivered result and checks accept-to-valid latency.
module tb_sma_rr_scheduler;
  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int CHW = 2;
  localparam int W   = CHW + DW;
  localparam int TMO = 60;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state_dbg;

  sma_rr_scheduler_if #(.N_CH(NCH), .DATA_W(DW)) bus ();

  sma_rr_scheduler #(.N_CH(NCH), .DATA_W(DW), .WIN(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1);
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int acc_cyc  = 0;
  logic prev_ov = 1'b0;

  function automatic void check(input string name, input logic signed [31:0] act,
                                input logic signed [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endfunction

  function automatic void note_timeout(input string name);
    n_checks++;
    $display("FAIL timeout_%s: event not seen within %0d cycles (t=%0t)", name, TMO, $time);
  endfunction

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst) begin
      if (|(bus.in_valid & bus.in_ready)) acc_cyc = cyc;
      if (bus.out_valid && !prev_ov) check("latency", cyc - acc_cyc, 2);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL out_spurious: ch=%0d data=%0d, expected no result", bus.out_ch,
                   $signed(bus.out_data));
        end else begin
          e = exp_q.pop_front();
          check("out_ch", bus.out_ch, e[W-1:DW]);
          check("out_data", $signed(bus.out_data), $signed(e[DW-1:0]));
        end
      end
    end
    prev_ov = bus.out_valid;
  end

  // driver tasks
  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_ch", bus.out_ch, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_state", state_dbg, 0);
    bus.in_valid = '0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic send(input int ch, input logic signed [15:0] x,
                      input logic signed [15:0] e, input bit push);
    int t;
    t = 0;
    bus.in_data[ch*DW +: DW] = x;
    bus.in_valid[ch] = 1'b1;
    @(negedge clk);
    while (!bus.in_ready[ch] && t < TMO) begin @(negedge clk); t++; end
    if (!bus.in_ready[ch]) note_timeout("grant");
    else if (push) exp_q.push_back({CHW'(ch), e});
    @(posedge clk); #1;
    bus.in_valid[ch] = 1'b0;
  endtask

  task automatic wait_out_valid();
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.out_valid && t < TMO) begin @(negedge clk); t++; end
    if (!bus.out_valid) note_timeout("out_valid");
  endtask

  task automatic drain();
    int t;
    t = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || state_dbg != 2'd0) && t < TMO) begin @(negedge clk); t++; end
    if (exp_q.size() != 0) note_timeout("drain");
    @(posedge clk); #1;
  endtask

  int t1_exp[5] = '{25, 50, 75, 100, 100};
  int t2_exp[4] = '{-1, -3, -5, -7};

  initial begin
    int ec;
    int t;
    rst = 1'b1;
    bus.in_valid = '0;
    bus.in_data = '0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    #2;
    bus.in_valid = '1;
    do_reset();

    // ch0 constant 100
    for (int k = 0; k < 5; k++) send(0, 16'sd100, 16'(t1_exp[k]), 1'b1);
    drain();

    // ch1 negative, then untouched channels and ch0 history
    for (int k = 0; k < 4; k++) send(1, -16'sd7, 16'(t2_exp[k]), 1'b1);
    send(2, 16'sd8, 16'sd2, 1'b1);
    send(3, 16'sd8, 16'sd2, 1'b1);
    send(0, 16'sd8, 16'sd77, 1'b1);
    drain();

    // all channels requesting
    do_reset();
    for (int i = 0; i < NCH; i++) bus.in_data[i*DW +: DW] = 16'(40 * (i + 1));
    bus.in_valid = '1;
    for (int n = 0; n < 6; n++) begin
      ec = n % NCH;
      t = 0;
      @(negedge clk);
      while (bus.in_ready == '0 && t < TMO) begin @(negedge clk); t++; end
      if (bus.in_ready == '0) note_timeout("rr_grant");
      else begin
        check("rr_grant", bus.in_ready, 4'b0001 << ec);
        exp_q.push_back({CHW'(ec), 16'(10 * (ec + 1) * ((n < NCH) ? 1 : 2))});
      end
      @(posedge clk); #1;
    end
    bus.in_valid = '0;
    drain();

    // backpressure in HOLD
    bus.out_ready = 1'b0;
    send(2, 16'sd120, 16'sd60, 1'b1);
    wait_out_valid();
    for (int i = 0; i < NCH; i++) bus.in_data[i*DW +: DW] = 16'(40 * (i + 1));
    bus.in_valid = '1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_valid", bus.out_valid, 1);
      check("hold_data", $signed(bus.out_data), 60);
      check("hold_ch", bus.out_ch, 2);
      check("hold_in_ready", bus.in_ready, 0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    t = 0;
    @(negedge clk);
    while (bus.in_ready == '0 && t < TMO) begin @(negedge clk); t++; end
    if (bus.in_ready == '0) note_timeout("post_hold_grant");
    else begin
      check("post_hold_grant", bus.in_ready, 4'b1000);
      exp_q.push_back({CHW'(3), 16'sd80});
    end
    @(posedge clk); #1;
    bus.in_valid = '0;
    drain();

    // reset during COMPUTE discards the in-flight sample
    send(2, 16'sd400, 16'sd0, 1'b0);
    do_reset();
    send(2, 16'sd40, 16'sd10, 1'b1);
    drain();

    // flush while a result is held
    bus.out_ready = 1'b0;
    send(0, 16'sd100, 16'sd25, 1'b1);
    wait_out_valid();
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(0, 16'sd100, 16'sd25, 1'b1);
    drain();

    // flush in IDLE blocks that cycle's grant
    bus.flush = 1'b1;
    bus.in_data[1*DW +: DW] = -16'sd7;
    bus.in_valid[1] = 1'b1;
    @(negedge clk);
    check("flush_idle_no_grant", bus.in_ready, 0);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    send(1, -16'sd7, -16'sd1, 1'b1);
    drain();

    check("exp_q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
